// File: rtl/core_pkg.sv
// Shared RV32I decode types: immediate-select codes, opcodes, result-source
// encodings and the control bundle carried from decode to execute.
package core_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_B  = 3'b010,
        IMM_J  = 3'b011,
        IMM_IU = 3'b100,
        IMM_SH = 3'b101,
        IMM_BU = 3'b110,
        IMM_U  = 3'b111
    } immsrc_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        immsrc_e    immsrc;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       alusrc;
        logic [1:0] resultsrc;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{IMM_I, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RES_ALU};

endpackage

// File: rtl/decode_ctrl_main_dec.sv
// Combinational opcode/funct3 decoder producing the control bundle and an illegal flag.
// ZEXT_IMM_EN enables the zero-extended immediate selects for sltiu and bltu/bgeu.
module decode_ctrl_main_dec
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        // Compressed/reserved encodings (low bits != 11) never reach the case below
        if (opcode[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    ctrl.regwrite = 1'b1;
                end
                OPC_OP_IMM: begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    if (funct3 == 3'b001 || funct3 == 3'b101) ctrl.immsrc = IMM_SH;
`ifdef ZEXT_IMM_EN
                    else if (funct3 == 3'b011) ctrl.immsrc = IMM_IU;
`endif
                end
                OPC_LOAD: begin
                    ctrl.regwrite  = 1'b1;
                    ctrl.alusrc    = 1'b1;
                    ctrl.resultsrc = RES_MEM;
                end
                OPC_STORE: begin
                    ctrl.immsrc   = IMM_S;
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                end
                OPC_BRANCH: begin
                    ctrl.immsrc = IMM_B;
                    ctrl.branch = 1'b1;
`ifdef ZEXT_IMM_EN
                    if (funct3[2:1] == 2'b11) ctrl.immsrc = IMM_BU;
`endif
                end
                OPC_JAL: begin
                    ctrl.immsrc    = IMM_J;
                    ctrl.jump      = 1'b1;
                    ctrl.regwrite  = 1'b1;
                    ctrl.resultsrc = RES_PC4;
                end
                OPC_JALR: begin
                    ctrl.jump      = 1'b1;
                    ctrl.regwrite  = 1'b1;
                    ctrl.alusrc    = 1'b1;
                    ctrl.resultsrc = RES_PC4;
                end
                OPC_LUI, OPC_AUIPC: begin
                    ctrl.immsrc   = IMM_U;
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                end
                OPC_FENCE: ;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: D-stage register with fetch/execute handshakes and an
// illegal-instruction trap state. Build option: ZEXT_IMM_EN (see main decoder).
module decode_ctrl
    import core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instrF_i,
    input  logic        validF_i,
    output logic        readyF_o,
    input  logic        flushD_i,
    output logic [24:0] instrD_o,
    output logic [2:0]  immsrcD_o,
    output logic        regwriteD_o,
    output logic        memwriteD_o,
    output logic        branchD_o,
    output logic        jumpD_o,
    output logic        alusrcD_o,
    output logic [1:0]  resultsrcD_o,
    output logic        validE_o,
    input  logic        readyE_i,
    output logic        illegal_o,
    input  logic        trap_ack_i
);

    // Encoding chosen so validE_o and illegal_o are direct register bits
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        VALID = 2'b01,
        TRAP  = 2'b10
    } state_e;

    state_e      state;
    ctrl_t       ctrl_q;
    logic [24:0] instr_q;
    ctrl_t       dec_ctrl;
    logic        dec_illegal;
    logic        accept;

    decode_ctrl_main_dec u_main_dec (
        .opcode  (instrF_i[6:0]),
        .funct3  (instrF_i[14:12]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign readyF_o = !flushD_i && (state == EMPTY || (state == VALID && readyE_i));
    assign accept   = validF_i && readyF_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= EMPTY;
            ctrl_q  <= CTRL_NOP;
            instr_q <= '0;
        end else if (flushD_i) begin
            state  <= EMPTY;
            ctrl_q <= CTRL_NOP;
        end else begin
            case (state)
                EMPTY, VALID: begin
                    if (accept) begin
                        state   <= dec_illegal ? TRAP : VALID;
                        ctrl_q  <= dec_ctrl;
                        instr_q <= instrF_i[31:7];
                    end else if (state == VALID && readyE_i) begin
                        // Consumed with nothing behind it: fields hold, only valid drops
                        state <= EMPTY;
                    end
                end
                TRAP: begin
                    if (trap_ack_i) begin
                        state  <= EMPTY;
                        ctrl_q <= CTRL_NOP;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign instrD_o     = instr_q;
    assign immsrcD_o    = ctrl_q.immsrc;
    assign regwriteD_o  = ctrl_q.regwrite;
    assign memwriteD_o  = ctrl_q.memwrite;
    assign branchD_o    = ctrl_q.branch;
    assign jumpD_o      = ctrl_q.jump;
    assign alusrcD_o    = ctrl_q.alusrc;
    assign resultsrcD_o = ctrl_q.resultsrc;
    assign validE_o     = state[0];
    assign illegal_o    = state[1];

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: directed test-plan sequences plus randomized traffic,
// checked by a queue-based scoreboard against an instruction-level reference model.
module tb_decode_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] instrF_i;
    logic        validF_i, readyF_o, flushD_i;
    logic [24:0] instrD_o;
    logic [2:0]  immsrcD_o;
    logic        regwriteD_o, memwriteD_o, branchD_o, jumpD_o, alusrcD_o;
    logic [1:0]  resultsrcD_o;
    logic        validE_o, readyE_i, illegal_o, trap_ack_i;

    decode_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .instrF_i(instrF_i), .validF_i(validF_i),
        .readyF_o(readyF_o), .flushD_i(flushD_i), .instrD_o(instrD_o),
        .immsrcD_o(immsrcD_o), .regwriteD_o(regwriteD_o), .memwriteD_o(memwriteD_o),
        .branchD_o(branchD_o), .jumpD_o(jumpD_o), .alusrcD_o(alusrcD_o),
        .resultsrcD_o(resultsrcD_o), .validE_o(validE_o), .readyE_i(readyE_i),
        .illegal_o(illegal_o), .trap_ack_i(trap_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Expected view of one held instruction
    typedef struct {
        logic        ill;
        logic [2:0]  imm;
        logic [4:0]  bits;   // regwrite, memwrite, branch, jump, alusrc
        logic [1:0]  res;
        logic [24:0] instr;
    } exp_t;

    exp_t exp_q[$];
    logic exp_rdy = 1'b1;
    logic mon_en  = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    // Reference model: instruction word -> expected D-stage contents
    function automatic exp_t ref_dec(input logic [31:0] i);
        exp_t e;
        int   f3;
        f3 = int'(i[14:12]);
        e.ill = 1'b0; e.imm = 3'd0; e.bits = 5'b00000; e.res = 2'd0; e.instr = i[31:7];
        if (i[1:0] != 2'b11) e.ill = 1'b1;
        else case (i[6:0])
            7'h33: e.bits = 5'b10000;
            7'h13: begin
                e.bits = 5'b10001;
                if (f3 == 1 || f3 == 5) e.imm = 3'd5;
`ifdef ZEXT_IMM_EN
                if (f3 == 3) e.imm = 3'd4;
`endif
            end
            7'h03: begin e.bits = 5'b10001; e.res = 2'd1; end
            7'h23: begin e.bits = 5'b01001; e.imm = 3'd1; end
            7'h63: begin
                e.bits = 5'b00100; e.imm = 3'd2;
`ifdef ZEXT_IMM_EN
                if (f3 >= 6) e.imm = 3'd6;
`endif
            end
            7'h6F: begin e.bits = 5'b10010; e.imm = 3'd3; e.res = 2'd2; end
            7'h67: begin e.bits = 5'b10011; e.res = 2'd2; end
            7'h37, 7'h17: begin e.bits = 5'b10001; e.imm = 3'd7; end
            7'h0F: ;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus; the scoreboard queue is updated at the edge the DUT sees it
    task automatic step(input logic v, input logic [31:0] ins, input logic re,
                        input logic fl, input logic ack);
        logic occ, rdy, do_pop, do_clr, do_push;
        validF_i = v; instrF_i = ins; readyE_i = re; flushD_i = fl; trap_ack_i = ack;
        occ     = exp_q.size() > 0;
        rdy     = !fl && (!occ || (!exp_q[0].ill && re));
        exp_rdy = rdy;
        do_clr  = fl;
        do_pop  = !fl && occ && (exp_q[0].ill ? ack : re);
        do_push = v && rdy;
        @(posedge clk_i);
        if (do_clr) exp_q.delete();
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(ref_dec(ins));
        #1;
    endtask

    // Monitor: compare whatever the DUT presents against the scoreboard head
    always @(negedge clk_i) begin
        if (mon_en && rst_ni) begin
            chk("mon_ready", 64'(readyF_o), 64'(exp_rdy));
            if (exp_q.size() == 0) begin
                chk("mon_idle", 64'({validE_o, illegal_o}), 64'(2'b00));
            end else begin
                chk("mon_flags", 64'({validE_o, illegal_o}),
                    64'({!exp_q[0].ill, exp_q[0].ill}));
                chk("mon_bundle",
                    64'({immsrcD_o, regwriteD_o, memwriteD_o, branchD_o, jumpD_o,
                         alusrcD_o, resultsrcD_o, instrD_o}),
                    64'({exp_q[0].imm, exp_q[0].bits, exp_q[0].res, exp_q[0].instr}));
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [11];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h7B};
        r = $urandom;
        if ($urandom_range(0, 15) != 0) r[6:0] = ops[$urandom_range(0, 10)];
        return r;
    endfunction

    localparam logic [31:0] ADDI = 32'h00500093, SH = 32'h00209023, JAL = 32'h0000006F;
    localparam logic [31:0] LUI  = 32'h123450B7, BAD = 32'hFFFFFFFF;
    localparam logic [31:0] BLTU = 32'h0020E063, SLTIU = 32'h0010B093, SLLI = 32'h00209093;

    initial begin
        rst_ni = 1'b0; validF_i = 1'b0; instrF_i = '0; readyE_i = 1'b0;
        flushD_i = 1'b0; trap_ack_i = 1'b0;
        #1;
        chk("reset_outs", 64'({validE_o, illegal_o, immsrcD_o, regwriteD_o, memwriteD_o,
                               branchD_o, jumpD_o, alusrcD_o, resultsrcD_o, instrD_o}), 64'd0);
        chk("reset_ready", 64'(readyF_o), 64'd1);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        mon_en = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("idle_empty", 64'({validE_o, readyF_o}), 64'(2'b01));

        // Back-to-back issue
        step(1, ADDI, 1, 0, 0); chk("b2b_addi_imm", 64'(immsrcD_o), 64'd0);
        step(1, SH,   1, 0, 0); chk("b2b_sh_imm",   64'(immsrcD_o), 64'd1);
        step(1, JAL,  1, 0, 0); chk("b2b_jal_imm",  64'(immsrcD_o), 64'd3);
        chk("b2b_jal_ctl", 64'({validE_o, jumpD_o, resultsrcD_o}), 64'(4'b1110));
        step(0, 0, 1, 0, 0);

        // Stall with lui held
        step(1, LUI, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, ADDI, 0, 0, 0);
            chk("stall_imm", 64'({immsrcD_o, readyF_o, validE_o}), 64'({3'd7, 1'b0, 1'b1}));
        end
        step(1, ADDI, 1, 0, 0); chk("stall_release", 64'(immsrcD_o), 64'd0);

        // Flush blocks a same-cycle fetch
        step(1, JAL, 1, 1, 0);
        chk("flush_valid", 64'({validE_o, illegal_o, jumpD_o}), 64'd0);

        // Illegal trap
        step(1, BAD, 1, 0, 0);
        chk("trap_enter", 64'({illegal_o, validE_o, readyF_o}), 64'(3'b100));
        for (int k = 0; k < 2; k++) begin
            step(1, ADDI, 1, 0, 0);
            chk("trap_hold", 64'({illegal_o, validE_o, readyF_o}), 64'(3'b100));
        end
        step(0, 0, 1, 0, 1);
        chk("trap_exit", 64'({illegal_o, validE_o, readyF_o}), 64'(3'b001));

        // Build-dependent immediate selects
        step(1, BLTU, 1, 0, 0);
`ifdef ZEXT_IMM_EN
        chk("bltu_imm", 64'(immsrcD_o), 64'd6);
`else
        chk("bltu_imm", 64'(immsrcD_o), 64'd2);
`endif
        step(1, SLTIU, 1, 0, 0);
`ifdef ZEXT_IMM_EN
        chk("sltiu_imm", 64'(immsrcD_o), 64'd4);
`else
        chk("sltiu_imm", 64'(immsrcD_o), 64'd0);
`endif
        step(1, SLLI, 1, 0, 0); chk("slli_imm", 64'(immsrcD_o), 64'd5);
        step(0, 0, 1, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);

        // Asynchronous reset mid-stream
        step(1, LUI, 0, 0, 0);
        #3 rst_ni = 1'b0;
        #1;
        chk("async_rst_outs", 64'({validE_o, illegal_o, immsrcD_o, regwriteD_o, alusrcD_o,
                                   instrD_o}), 64'd0);
        chk("async_rst_ready", 64'(readyF_o), 64'd1);
        exp_q.delete();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("post_rst_idle", 64'({validE_o, illegal_o, readyF_o}), 64'(3'b001));
        step(1, JAL, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Decode-stage controller for the RV32I pipeline. It accepts instructions from fetch over a valid/ready handshake and holds each one in the D-stage register. The held instruction drives the immediate extender: it supplies `instrD_o[31:7]` and the registered `immsrcD_o` select. When execute accepts, it forwards the decoded control bundle; illegal opcodes are trapped until acknowledged.

## Interface
- No parameters.
- `clk_i  in  1`: core clock.
- `rst_ni  in  1`: reset, asynchronous, active-low.
- `instrF_i  in  32`: fetched instruction.
- `validF_i  in  1`: `instrF_i` valid.
- `readyF_o  out  1`: D stage can accept.
- `flushD_i  in  1`: discard D-stage contents (branch redirect).
- `instrD_o  out  25`: held `instr[31:7]`, to extender.
- `immsrcD_o  out  3`: extender select, registered.
- `regwriteD_o`, `memwriteD_o`, `branchD_o`, `jumpD_o`, `alusrcD_o`: `out  1` each, control bits.
- `resultsrcD_o  out  2`: 00 ALU, 01 memory, 10 PC+4.
- `validE_o  out  1`: D-stage bundle valid for execute.
- `readyE_i  in  1`: execute accepts.
- `illegal_o  out  1`: illegal instruction held in D.
- `trap_ack_i  in  1`: trap handler acknowledge.

## Operation
- **FSM states:**
  - `EMPTY`: reset state.
  - `VALID`: holding a legal instruction.
  - `TRAP`: holding an illegal instruction.
- **Handshakes:**
  - `readyF_o` = EMPTY | (VALID & `readyE_i`).
  - `validE_o` = VALID.
  - `illegal_o` = TRAP.
- **Fetch acceptance:** an instruction is accepted when `validF_i & readyF_o`. It is decoded combinationally, then registered together with `instrF_i[31:7]`.
- **Transitions:**
  - EMPTY → VALID: accept, legal.
  - EMPTY → TRAP: accept, illegal.
  - VALID, `readyE_i` without accept → EMPTY.
  - VALID, `readyE_i` with accept → VALID or TRAP. This is back-to-back issue, no bubble.
  - VALID, `!readyE_i` → hold. All outputs remain stable.
  - TRAP, `trap_ack_i` → EMPTY.
  - TRAP otherwise → hold. `readyF_o` = 0.
- **Flush:** `flushD_i` has priority over everything. In VALID or EMPTY it forces EMPTY and blocks the same-cycle accept (`readyF_o` is masked to 0). `flushD_i` also clears TRAP to EMPTY; `trap_ack_i` is then don't-care.
- **Opcode decode:** `immsrcD_o`, followed by the control bits.
  - `0110011` OP: imm 000. `regwrite`.
  - `0010011` OP-IMM: imm 000 by default. `funct3` 001/101 → 101 (shamt). `funct3` 011 (sltiu) → 100 with macro, else 000. `regwrite`, `alusrc`.
  - `0000011` LOAD: imm 000. `regwrite`, `alusrc`, `resultsrc` 01.
  - `0100011` STORE: imm 001. `memwrite`, `alusrc`.
  - `1100011` BRANCH: imm 010. `funct3` 110/111 → 110 with macro. `branch`.
  - `1101111` JAL: imm 011. `jump`, `regwrite`, `resultsrc` 10.
  - `1100111` JALR: imm 000. `jump`, `regwrite`, `alusrc`, `resultsrc` 10.
  - `0110111` LUI and `0010111` AUIPC: imm 111. `regwrite`, `alusrc`.
  - `0001111` FENCE: legal. All control bits 0.
  - Anything else, or `instr[1:0]` ≠ 11: illegal. All control bits 0, imm 000.

## Timing
- **Reset:** state EMPTY. All registered outputs are 0, including `instrD_o`, `immsrcD_o`, the control bits, `validE_o` and `illegal_o`. `readyF_o` = 1.
- **Latency:** one cycle. An instruction accepted at edge N is visible on the D outputs after N.
- **Throughput:** one instruction per cycle while `readyE_i` = 1.
- **Hold:** D outputs change only on accept, flush or trap exit. A flush or trap exit zeroes the control bits; `instrD_o` may hold its value.
- **Reset mid-operation:** return to EMPTY immediately. No instruction survives.
- **Combinational paths:** `readyF_o` depends combinationally on `readyE_i` and `flushD_i`. No other combinational input-to-output path exists.

## Configuration
- **`ZEXT_IMM_EN`** defined:
  - sltiu selects 100 (I-type zero-extended).
  - bltu/bgeu select 110 (B-type zero-extended).
- **Undefined:** sltiu selects 000 and bltu/bgeu select 010. Codes 100/110 are never produced.

## Structure
- **`core_pkg`:**
  - `immsrc_e` enum: `IMM_I`=000, `IMM_S`=001, `IMM_B`=010, `IMM_J`=011, `IMM_IU`=100, `IMM_SH`=101, `IMM_BU`=110, `IMM_U`=111.
  - Opcode localparams.
  - `resultsrc` encodings.
  - `ctrl_t` struct holding the control bundle.
- **Local to this module:** the state enum, `{EMPTY, VALID, TRAP}`.
- **Sub-module `decode_ctrl_main_dec`:** purely combinational opcode/`funct3` → `ctrl_t` + illegal. Instantiated once, before the D register.

## Test plan
- **Reset:** assert `rst_ni`=0 mid-stream → all outputs 0 and `readyF_o`=1 asynchronously. Release; idle → still EMPTY.
- **Back-to-back issue:** issue `0x00500093` (addi), `0x00209023` (sh), `0x0000006F` (jal) back-to-back with `readyE_i`=1 → one per cycle.
  - `immsrcD_o` sequence 000, 001, 011.
  - jal shows `jumpD_o`=1 and `resultsrcD_o`=10.
- **Stall:** `readyE_i`=0 for 3 cycles with lui `0x123450B7` held → `immsrcD_o`=111 stable, `readyF_o`=0. `readyE_i`=1 → accept next.
- **Flush:** `flushD_i` with `validF_i`=1 → next cycle `validE_o`=0 and no instruction captured.
- **Illegal trap:** `0xFFFFFFFF` → `illegal_o`=1, `validE_o`=0, `readyF_o`=0 until `trap_ack_i`. EMPTY on the following cycle.
- **Macro variants:** `bltu` `0x0020E063` and `sltiu` `0x0010B093` → `immsrcD_o` 110/100 with `ZEXT_IMM_EN`, 010/000 without. `slli` `0x00209093` → 101 in both builds.
